// File: rtl/mem_refill_responder.sv
// mem_refill_responder: memory-side model for the cache refill interface.
// Holds a word-addressed backing RAM and answers each line request with
// 2^WORD_OFFSET single-cycle ack beats separated by GAP_CYCLES idle cycles,
// after LATENCY idle cycles. A backdoor port (ld_*) preloads the RAM.
//
// Handshake: req_cc2mem is a level held by the cache for the whole burst.
// A request is accepted on an edge in IDLE with req high. Each beat is a
// one-cycle ack_mem2cc pulse with dat_mem2cc valid in that cycle only.
// Dropping req before the burst ends aborts it on the next edge. After a
// completed burst req must go low for at least one edge before the next
// request can be accepted.
//
// Optional feature macro: MEM_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   : first beat is the requested word, later beats wrap in the line
//   undefined : beats always start at word 0 of the line

module mem_refill_responder #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2,
    parameter int MEM_AW      = 10,
    parameter int LATENCY     = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc2mem,
    input  logic [ADR_WIDTH-1:0]  adr_cc2mem,
    output logic                  ack_mem2cc,
    output logic [DATA_WIDTH-1:0] dat_mem2cc,
    output logic                  busy,
    input  logic                  ld_en,
    input  logic [MEM_AW-1:0]     ld_adr,
    input  logic [DATA_WIDTH-1:0] ld_dat
);

    localparam int LINE_W = MEM_AW - WORD_OFFSET;
    localparam int CNT_W  = 16;

    // S_BEAT is the cycle before an ack pulse: the beat is registered out on
    // the edge that leaves S_BEAT, so outputs stay fully registered.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   ram [0:(1<<MEM_AW)-1];
    logic [LINE_W-1:0]       line_idx;
    logic [WORD_OFFSET-1:0]  word_idx;
    logic [WORD_OFFSET-1:0]  beat_cnt;
    logic [WORD_OFFSET-1:0]  start_word;
    logic [CNT_W-1:0]        lat_cnt;
    logic [CNT_W-1:0]        gap_cnt;
    logic [MEM_AW-1:0]       rd_adr;
    logic                    unused_adr;

    // Address bits outside the word index (and [1:0]) carry no meaning here.
    assign unused_adr = ^adr_cc2mem;

    // Read address comes straight from registered line/word state, so it is
    // already stable during the cycle before the beat edge.
    assign rd_adr = {line_idx, word_idx};

`ifdef MEM_REFILL_CRITICAL_WORD_FIRST_EN
    // Critical word first: burst starts at the requested word.
    assign start_word = adr_cc2mem[WORD_OFFSET+1:2];
`else
    // Line order: burst always starts at word 0 of the line.
    assign start_word = '0;
`endif

    // Backdoor write port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            ram[ld_adr] <= ld_dat;
        end
    end

    // Refill FSM with registered ack/data/busy; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ack_mem2cc <= 1'b0;
            dat_mem2cc <= '0;
            busy       <= 1'b0;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
            beat_cnt   <= '0;
            word_idx   <= '0;
            line_idx   <= '0;
        end else begin
            ack_mem2cc <= 1'b0;
            dat_mem2cc <= '0;
            case (state)
                S_IDLE: begin
                    if (req_cc2mem) begin
                        line_idx <= adr_cc2mem[MEM_AW+1:WORD_OFFSET+2];
                        word_idx <= start_word;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        lat_cnt  <= CNT_W'(LATENCY);
                        state    <= (LATENCY == 0) ? S_BEAT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req_cc2mem) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                        if (lat_cnt == CNT_W'(1)) begin
                            state <= S_BEAT;
                        end
                    end
                end
                S_BEAT: begin
                    if (!req_cc2mem) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ack_mem2cc <= 1'b1;
                        dat_mem2cc <= ram[rd_adr];
                        word_idx   <= word_idx + 1'b1;
                        beat_cnt   <= beat_cnt + 1'b1;
                        if (&beat_cnt) begin
                            state <= S_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            state <= S_BEAT;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= CNT_W'(GAP_CYCLES);
                        end
                    end
                end
                S_GAP: begin
                    if (!req_cc2mem) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == CNT_W'(1)) begin
                            state <= S_BEAT;
                        end
                    end
                end
                S_DONE: begin
                    if (!req_cc2mem) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
